// File: rtl/adc_cap_pkg.sv
// adc_cap_pkg: shared state encoding and widths for the ADC capture sequencer
package adc_cap_pkg;
  typedef enum logic [2:0] {IDLE, ARMED, FILL, HANDOFF, DONE} state_t;
  localparam int BURST_LEN_DEF = 1024;
  localparam int FIFO_W = 16;
endpackage

// File: rtl/tgl_sync.sv
// tgl_sync: 2-FF synchronizer for a toggle crossing from the reader domain, one-cycle pulse per toggle
module tgl_sync (
  input  logic clk_65m,
  input  logic rstn_i,
  input  logic tgl,
  output logic pulse
);
  logic [2:0] s;
  always_ff @(posedge clk_65m or posedge rstn_i)
    if (rstn_i) s <= '0;
    else s <= {s[1:0], tgl};
  assign pulse = s[1] ^ s[2];
endmodule

// File: rtl/adc_capture_seq.sv
// adc_capture_seq: arms on start, waits for a trigger, bursts BURST_LEN samples into a FIFO,
// then hands each frame to the reader and waits for its toggle acknowledge
module adc_capture_seq
  import adc_cap_pkg::*;
#(
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int ADC_W = 12
) (
  input  logic              clk_65m,
  input  logic              rstn_i,
  input  logic              start,
  input  logic              abort,
  input  logic              trig_mode,
  input  logic [ADC_W-1:0]  trig_thresh,
  input  logic [7:0]        num_frames,
  input  logic [ADC_W-1:0]  adc_din,
  input  logic              fifo_full,
  input  logic              rd_ack_tgl,
  output logic              fifo_wr_en,
  output logic [FIFO_W-1:0] fifo_din,
  output logic              rd_req,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [7:0]        frame_cnt
);
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  state_t state, nxt;
  logic start_d, arm, ack, cfg_mode;
  logic [ADC_W-1:0] adc_q, adc_p, cfg_thresh;
  logic [7:0] cfg_frames;
  logic [CNT_W-1:0] smp_cnt;

  tgl_sync u_sync (.clk_65m(clk_65m), .rstn_i(rstn_i), .tgl(rd_ack_tgl), .pulse(ack));

  assign arm = state == IDLE && start && !start_d && !abort;
  assign busy = state != IDLE;
  // adc_p is written so the sample that satisfied the trigger is the first one stored
  assign fifo_din = FIFO_W'(adc_p);

  always_comb begin
    nxt = state;
    fifo_wr_en = 1'b0;
    rd_req = 1'b0;
    done = 1'b0;
    case (state)
      IDLE: nxt = arm ? ARMED : IDLE;
      ARMED: nxt = (!cfg_mode || (adc_p < cfg_thresh && adc_q >= cfg_thresh)) ? FILL : ARMED;
      FILL: begin
        fifo_wr_en = !fifo_full;
        nxt = (!fifo_full && smp_cnt == CNT_W'(BURST_LEN - 1)) ? HANDOFF : FILL;
      end
      HANDOFF: begin
        rd_req = 1'b1;
        nxt = !ack ? HANDOFF : (cfg_frames != 8'd0 && frame_cnt + 8'd1 == cfg_frames) ? DONE : ARMED;
      end
      DONE: begin
        done = 1'b1;
        nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
    if (abort) begin
      nxt = IDLE;
      fifo_wr_en = 1'b0;
      rd_req = 1'b0;
    end
  end

  always_ff @(posedge clk_65m or posedge rstn_i)
    if (rstn_i) begin
      state <= IDLE;
      start_d <= 1'b0;
      adc_q <= '0;
      adc_p <= '0;
      smp_cnt <= '0;
      frame_cnt <= '0;
      overflow <= 1'b0;
      cfg_mode <= 1'b0;
      cfg_thresh <= '0;
      cfg_frames <= '0;
    end else begin
      state <= nxt;
      start_d <= start;
      adc_q <= adc_din;
      adc_p <= adc_q;
      smp_cnt <= state != FILL ? '0 : smp_cnt + CNT_W'(fifo_wr_en);
      if (arm) begin
        frame_cnt <= '0;
        overflow <= 1'b0;
        cfg_mode <= trig_mode;
        cfg_thresh <= trig_thresh;
        cfg_frames <= num_frames;
      end else begin
        if (state == FILL && fifo_full && !abort) overflow <= 1'b1;
        if (state == HANDOFF && ack && !abort) frame_cnt <= frame_cnt + 8'd1;
      end
    end
endmodule

// File: doc/adc_capture_seq.md
ADC_CAPTURE_SEQ -- requirements
Module: adc_capture_seq

Interface
REQ-001 SHALL have parameter BURST_LEN, default 1024, meaning samples written per frame (1..1024).
REQ-002 SHALL have parameter ADC_W, default 12, meaning ADC sample width.
REQ-003 SHALL have port clk_65m input 1, capture/FIFO-write clock; all logic on its rising edge.
REQ-004 SHALL have port rstn_i input 1, reset: asynchronous, active-high.
REQ-005 SHALL have port start input 1, level; rising edge arms a capture.
REQ-006 SHALL have port abort input 1, synchronous; returns the block to IDLE.
REQ-007 SHALL have port trig_mode input 1, 0 = immediate, 1 = threshold crossing.
REQ-008 SHALL have port trig_thresh input ADC_W, unsigned trigger threshold.
REQ-009 SHALL have port num_frames input 8, frames per capture; 0 = continuous.
REQ-010 SHALL have port adc_din input ADC_W, raw ADC sample.
REQ-011 SHALL have port fifo_full input 1, FIFO write-side full.
REQ-012 SHALL have port rd_ack_tgl input 1, toggle from clk_100m reader, one toggle per drained frame.
REQ-013 SHALL have ports fifo_wr_en output 1 and fifo_din output 16, FIFO write strobe and data.
REQ-014 SHALL have port rd_req output 1, level; frame ready for reader.
REQ-015 SHALL have ports busy output 1, done output 1 (one-cycle pulse), overflow output 1 (sticky), frame_cnt output 8.

Function
REQ-016 SHALL register adc_din once; fifo_din = {zero-extend, sample registered previous cycle}.
REQ-017 SHALL implement states IDLE, ARMED, FILL, HANDOFF, DONE.
REQ-018 IDLE: start rising edge (start & !start_d) -> ARMED, frame_cnt cleared, overflow cleared; start edges in other states ignored.
REQ-019 ARMED: trig_mode=0 -> FILL next cycle; trig_mode=1 -> FILL when previous sample < trig_thresh and current registered sample >= trig_thresh.
REQ-020 FILL: fifo_wr_en = !fifo_full every cycle; sample counter increments only on actual write.
REQ-021 FILL with fifo_full high: sample dropped, overflow set, remains set until next arm or reset.
REQ-022 FILL -> HANDOFF in the cycle the BURST_LEN-th write occurs; no write in HANDOFF.
REQ-023 HANDOFF: rd_req = 1; rd_ack_tgl through 2-FF synchronizer, edge detected by XOR with prior synchronized value.
REQ-024 On ack edge: frame_cnt increments (wraps 255 -> 0); if num_frames != 0 and new count == num_frames -> DONE, else -> ARMED.
REQ-025 Ack edge outside HANDOFF SHALL be ignored and not queued.
REQ-026 DONE: done = 1 for exactly one cycle, -> IDLE.
REQ-027 abort, when high, overrides all transitions: -> IDLE next cycle, fifo_wr_en and rd_req low; frame_cnt and overflow retained.
REQ-028 busy = 1 in every state except IDLE.
REQ-029 num_frames, trig_mode, trig_thresh SHALL be sampled on the arm edge and held for the capture.

Reset
REQ-030 On rstn_i high: state IDLE, fifo_wr_en 0, fifo_din 0, rd_req 0, busy 0, done 0, overflow 0, frame_cnt 0, counters and synchronizer 0.
REQ-031 Reset mid-FILL or mid-HANDOFF SHALL abandon the frame with no further write or pulse after release.

Structure
REQ-032 State encodings, BURST_LEN default, and 16-bit FIFO data width SHALL live in a shared package adc_cap_pkg.
REQ-033 The 2-FF toggle synchronizer with edge output SHALL be a sub-module tgl_sync.
REQ-034 Implementation SHALL be 120-400 RTL lines with no latches and no clocks derived from data.

Verification
REQ-035 trig_mode=0, num_frames=1, BURST_LEN=1024, one ack toggle -> exactly 1024 writes, rd_req high, then done pulse, frame_cnt=1, busy low.
REQ-036 trig_mode=1, thresh=0x800, ramp 0x7F0..0x810 -> first write carries the first sample >= 0x800, i.e. 0x0800.
REQ-037 fifo_full forced high 10 cycles mid-FILL -> overflow=1, still 1024 writes total, writes absent while full.
REQ-038 num_frames=3, three ack toggles -> three 1024-write bursts, frame_cnt=3, single done pulse after third ack.
REQ-039 abort at write 500 -> IDLE next cycle, fifo_wr_en low, busy low, no done; subsequent start performs a fresh capture.
REQ-040 rstn_i pulsed during HANDOFF, then ack toggle -> all outputs at reset values, toggle ignored.
